sfr_status_flag_bank: RTL

//  Clocked status-flag bank: consumer end of the GSU event latches.
//  - Core-side pulses set flags; explicit clears have priority over sets.
//  - A host read snapshots all flags and clears the read-to-clear bits.
//  - A set arriving during the read-clear cycle is never lost.
//  - Drives the active-low host IRQ from the enabled flags.
//  - Sits between the GSU core event outputs and the SNES bus SFR read path.

---
 rtl/sfr_status_flag_bank.sv | 117 +++++++++++
 1 files changed

// File: rtl/sfr_status_flag_bank.sv
// rtl/sfr_status_flag_bank.sv - clocked status-flag bank with read-to-clear snapshot and IRQ
//
// Purpose:
//   Consumer end of the GSU event latches. Core-side pulses set flags,
//   explicit clears override sets, and a host read snapshots the flags and
//   then clears the read-to-clear subset one cycle later. The active-low IRQ
//   is the registered OR of the enabled flags.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous, active-high reset
//   set_i        per-bit set request, sampled every cycle
//   clear_i      per-bit clear request, highest priority
//   irq_en_i     per-bit IRQ enable
//   rd_strobe_i  host read request (level, may be held)
//   rd_data_o    snapshot of flags taken when the read was accepted
//   rd_valid_o   one-cycle pulse, rd_data_o valid
//   flags_o      current flag register
//   irq_n_o      active-low IRQ, registered

module sfr_status_flag_bank #(
    parameter int          NUM_FLAGS   = 8,
    parameter logic [15:0] CLR_ON_READ = 16'h00FF,
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_FLAGS-1:0] set_i,
    input  logic [NUM_FLAGS-1:0] clear_i,
    input  logic [NUM_FLAGS-1:0] irq_en_i,
    input  logic                 rd_strobe_i,
    output logic [NUM_FLAGS-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic [NUM_FLAGS-1:0] flags_o,
    output logic                 irq_n_o
);

    localparam logic [NUM_FLAGS-1:0] CLR_MASK  = CLR_ON_READ[NUM_FLAGS-1:0];
    localparam logic [NUM_FLAGS-1:0] RST_FLAGS = RESET_VALUE[NUM_FLAGS-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [NUM_FLAGS-1:0] snap_q, snap_d;
    logic [NUM_FLAGS-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 irq_n_q, irq_n_d;
    logic [NUM_FLAGS-1:0] rc_mask;

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rc_mask    = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Snapshot is the registered value, so a set in this same
                // cycle is not in snap and therefore survives the clear.
                if (rd_strobe_i) begin
                    snap_d     = flags_q;
                    rd_data_d  = flags_q;
                    rd_valid_d = 1'b1;
                    state_d    = ST_CLR;
                end
            end
            ST_CLR: begin
                // Only bits that were reported are cleared; sets landing in
                // this cycle are OR-ed in after the mask and are kept.
                rc_mask = snap_q & CLR_MASK;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Wait for strobe release so one assertion means one read.
                if (!rd_strobe_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flags_d = ((flags_q & ~rc_mask) | set_i) & ~clear_i;
        irq_n_d = ~|(flags_q & irq_en_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            flags_q    <= RST_FLAGS;
            snap_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            snap_q     <= snap_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_n_q    <= irq_n_d;
        end
    end

    assign flags_o    = flags_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign irq_n_o    = irq_n_q;

endmodule
